// File: rtl/spi_read_cache_pkg.sv
// Shared constants and state encoding for the SPI read cache.
// Optional stats ports are enabled by SPI_READ_CACHE_STATS_EN.
package spi_read_cache_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int IDX_W_DEF  = 4;
  localparam int BUS_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/spi_read_cache_array.sv
// Direct-mapped valid/tag/data storage for the SPI read cache.
// Combinational lookup, synchronous install, flush clears valid bits.
module spi_read_cache_array
  import spi_read_cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [BUS_W-1:0]  lk_data,
  input  logic              ins_en,
  input  logic [ADDR_W-1:0] ins_addr,
  input  logic [BUS_W-1:0]  ins_data
);

  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [BUS_W-1:0] data_q [LINES];

  logic [IDX_W-1:0] lk_idx, ins_idx;

  assign lk_idx  = lk_addr[IDX_W-1:0];
  assign ins_idx = ins_addr[IDX_W-1:0];

  assign lk_hit  = valid_q[lk_idx] &&
                   (tag_q[lk_idx] == lk_addr[ADDR_W-1:IDX_W]);
  assign lk_data = data_q[lk_idx];

  // Flush wins over a same-edge install.
  always_comb begin
    valid_d = valid_q;
    if (ins_en) valid_d[ins_idx] = 1'b1;
    if (flush)  valid_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (ins_en) begin
      tag_q[ins_idx]  <= ins_addr[ADDR_W-1:IDX_W];
      data_q[ins_idx] <= ins_data;
    end
  end

endmodule

// File: rtl/spi_read_cache.sv
// Write-through, write-allocate byte cache in front of the SPI memory.
// Define SPI_READ_CACHE_STATS_EN for hit_count/miss_count outputs.
module spi_read_cache
  import spi_read_cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BUS_W-1:0]  cpu_wdata,
  input  logic              cpu_write,
  input  logic              cpu_valid,
  output logic [BUS_W-1:0]  cpu_rdata,
  output logic              cpu_ready,
`ifdef SPI_READ_CACHE_STATS_EN
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BUS_W-1:0]  mem_wdata,
  output logic              mem_write,
  output logic              mem_valid,
  input  logic [BUS_W-1:0]  mem_rdata,
  input  logic              mem_ready
);

  state_e              state_q, state_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic [BUS_W-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BUS_W-1:0]    mem_wdata_q, mem_wdata_d;

  logic                lk_hit;
  logic [BUS_W-1:0]    lk_data;
  logic                ins_en;
  logic [BUS_W-1:0]    ins_data;

  assign ins_en   = (state_q == MEM) && mem_ready;
  assign ins_data = mem_write_q ? mem_wdata_q : mem_rdata;

  spi_read_cache_array #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .lk_addr  (cpu_addr),
    .lk_hit   (lk_hit),
    .lk_data  (lk_data),
    .ins_en   (ins_en),
    .ins_addr (mem_addr_q),
    .ins_data (ins_data)
  );

  always_comb begin
    state_d     = state_q;
    cpu_ready_d = cpu_ready_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_write_d = cpu_write;
          if (!cpu_write && lk_hit) begin
            cpu_rdata_d = lk_data;
            cpu_ready_d = 1'b1;
            state_d     = RESP;
          end else begin
            mem_valid_d = 1'b1;
            state_d     = MEM;
          end
        end
      end
      MEM: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          cpu_rdata_d = mem_write_q ? '0 : mem_rdata;
          cpu_ready_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        cpu_ready_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        cpu_ready_d = 1'b0;
        mem_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef SPI_READ_CACHE_STATS_EN
  logic [15:0] hit_q, hit_d;
  logic [15:0] miss_q, miss_d;
  logic        rd_acc;

  assign rd_acc = (state_q == IDLE) && cpu_valid && !cpu_write;

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (flush) begin
      hit_d  = '0;
      miss_d = '0;
    end else if (rd_acc && lk_hit) begin
      hit_d = (hit_q == 16'hFFFF) ? hit_q : hit_q + 16'd1;
    end else if (rd_acc) begin
      miss_d = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: doc/spi_read_cache.md
Name: spi_read_cache

Overview:
- Direct-mapped, byte-granular, write-through cache between the zwolf CPU memory port and the SPI memory controller.
- Serial RAM access costs tens of cycles per byte. The cache answers repeated reads (instruction loops, stack) in 1 cycle.
- Slave on the CPU mem_* bus, master on the SPI controller bus. Both sides use the same valid/ready/write protocol.
- Flushed externally, e.g. on I2C-driven CPU reset or after an I2C memory write.

Parameters:
- ADDR_W, 13, byte address width on both buses.
- IDX_W, 4, index bits. Cache holds 2**IDX_W one-byte lines. Tag width is ADDR_W-IDX_W.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  level or pulse. Invalidates all lines.
- cpu_addr  in  ADDR_W  CPU request address.
- cpu_wdata  in  8  CPU write data.
- cpu_write  in  1  1=write, 0=read.
- cpu_valid  in  1  CPU request valid. Held until cpu_ready.
- cpu_rdata  out  8  read data. Valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_W  to SPI controller.
- mem_wdata  out  8  to SPI controller.
- mem_write  out  1  to SPI controller.
- mem_valid  out  1  to SPI controller. Held until mem_ready.
- mem_rdata  in  8  from SPI controller.
- mem_ready  in  1  from SPI controller. One-cycle pulse.

Behaviour:
- Reset (async, resetn=0):
  - All line valid bits cleared.
  - cpu_ready=0, cpu_rdata=0, mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - state=IDLE.
  - Tag and data arrays need not be reset.
- Address split: idx=addr[IDX_W-1:0], tag=addr[ADDR_W-1:IDX_W]. Hit = valid[idx] && tag_q[idx]==tag.
- FSM states: IDLE, MEM, RESP.
- IDLE, cpu_valid=1:
  - Registers addr, wdata and write.
  - Read hit: cpu_rdata<=data[idx], go RESP. Latency is 1 cycle from valid to ready.
  - Read miss: drive mem_valid=1, mem_write=0, mem_addr=addr, go MEM.
  - Write (hit or miss): drive mem_valid=1, mem_write=1, mem_addr, mem_wdata, go MEM. Write-through, write-allocate.
- MEM:
  - mem_* outputs stay stable until mem_ready.
  - On mem_ready: mem_valid<=0 and install the line (valid=1, tag, data). Data is mem_rdata for a read or the registered wdata for a write.
  - Read: cpu_rdata<=mem_rdata. Write: cpu_rdata<=0.
  - Go RESP.
- RESP: cpu_ready=1 for exactly one cycle, then IDLE.
  - The master drops or changes cpu_valid on the edge where it samples ready.
  - IDLE does not sample cpu_valid in the RESP cycle.
- cpu_ready is never asserted outside RESP. mem_valid is never asserted outside MEM.
- flush:
  - Any cycle with flush=1 clears all valid bits at the next edge.
  - Flush has priority over an install on the same edge: the completing transaction returns data to the CPU but leaves its line invalid.
  - A read hit looked up in the same cycle as flush still returns the cached data.
  - Flush does not abort an in-flight MEM transaction.
- Aliasing: addresses sharing an index evict each other. Last install wins.
- Reset mid-transaction abandons the SPI request: mem_valid drops asynchronously. The SPI controller shares resetn.

Optional Feature:
- Macro: SPI_READ_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Read hits increment hit_count. Read misses increment miss_count. Writes are not counted.
  - Both counters saturate at 16'hFFFF. Both clear on reset and on flush.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package/header: ADDR_W default, state encodings (IDLE=2'd0, MEM=2'd1, RESP=2'd2), bus width constant 8.
- One natural sub-module, spi_read_cache_array: holds the valid/tag/data arrays.
  - Combinational lookup.
  - Synchronous install port.
  - Asynchronous clear of valid bits, plus synchronous clear on flush.
- The FSM and bus muxing stay in the parent.

Test Plan:
- Cold read of 0x0123 → mem_valid, mem_addr=0x0123, mem_write=0. Model returns 0x5A after 20 cycles → cpu_rdata=0x5A with cpu_ready one cycle after mem_ready. Line 3 becomes valid.
- Re-read 0x0123 → cpu_ready exactly 1 cycle after valid, rdata=0x5A, mem_valid stays 0.
- Write 0x0A7 to 0x0103 (same index 3, different tag) → write-through on the mem bus with wdata=0xA7. Subsequent read of 0x0103 hits with 0xA7. Read of 0x0123 misses.
- Read hit, then pulse flush, then repeat the read → miss, mem_valid issued. With STATS_EN: hit_count=0, miss_count=1 after the repeat.
- flush asserted in the same cycle as mem_ready for a read of 0x1FFF → CPU gets the data; the next read of 0x1FFF misses.
- resetn low while in MEM → mem_valid and cpu_ready go 0 immediately. After release, a read of a previously cached address misses.
